// File: rtl/mesm6_mem_pkg.sv
// Shared types and constants for the MESM-6 memory-side bridge:
// FSM state encoding, word/halfword/address widths and halfword slice helpers.
package mesm6_mem_pkg;

  localparam int MESM6_WORD_W   = 48;
  localparam int MESM6_HALF_W   = 16;
  localparam int MESM6_ADDR_W   = 15;
  localparam int MESM6_HALF_CNT = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_PH = 2'd1,
    WR_PH = 2'd2,
    DONE  = 2'd3
  } mesm6_state_e;

  // idx 0 is the most significant halfword; idx 3 never occurs
  function automatic logic [MESM6_HALF_W-1:0] get_half(
    input logic [MESM6_WORD_W-1:0] word,
    input logic [1:0]              idx
  );
    case (idx)
      2'd0:    get_half = word[47:32];
      2'd1:    get_half = word[31:16];
      default: get_half = word[15:0];
    endcase
  endfunction

  function automatic logic [MESM6_WORD_W-1:0] set_half(
    input logic [MESM6_WORD_W-1:0] word,
    input logic [1:0]              idx,
    input logic [MESM6_HALF_W-1:0] half
  );
    set_half = word;
    case (idx)
      2'd0:    set_half[47:32] = half;
      2'd1:    set_half[31:16] = half;
      default: set_half[15:0]  = half;
    endcase
  endfunction

endpackage

// File: rtl/mesm6_wait_counter.sv
// Per-phase wait-state down-counter; loads WAIT_STATES at phase start and
// flags the final cycle of the phase when it reaches zero.
module mesm6_wait_counter #(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic phase_last
);

  logic [2:0] cnt_q;
  logic [2:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = 3'(WAIT_STATES);
    end else if (cnt_q != 3'd0) begin
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 3'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_last = (cnt_q == 3'd0);

endmodule

// File: rtl/mesm6_sram_bridge.sv
// Bridges 48-bit MESM-6 word accesses onto a 16-bit async SRAM as three phases.
// Optional one-entry read buffer: define MESM6_SRAM_RDBUF_EN.
module mesm6_sram_bridge
  import mesm6_mem_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [14:0] mem_addr,
  input  logic [47:0] mem_data_write,
  output logic        mem_done,
  output logic [47:0] mem_data_read,
  output logic [16:0] sram_addr,
  output logic [15:0] sram_dq_o,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce,
  output logic        sram_oe,
  output logic        sram_we
);

  mesm6_state_e state_q, state_d;
  logic [1:0]   idx_q, idx_d;
  logic [14:0]  addr_q, addr_d;
  logic [47:0]  wdata_q, wdata_d;
  logic [47:0]  rd_asm_q, rd_asm_d;
  logic [47:0]  rdata_q, rdata_d;
  logic [47:0]  rd_cap;
  logic         load;
  logic         phase_last;
  logic         rd_last;
  logic         buf_hit;
  logic [47:0]  buf_rdata;

  mesm6_wait_counter #(.WAIT_STATES(WAIT_STATES)) u_wait (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .phase_last (phase_last)
  );

  assign rd_cap  = set_half(rd_asm_q, idx_q, sram_dq_i);
  assign rd_last = (state_q == RD_PH) && phase_last && (idx_q == 2'd2);

  // mem_data_read is loaded on the edge into DONE so it is already valid there
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rd_asm_d = rd_asm_q;
    rdata_d  = rdata_q;
    load     = 1'b0;
    case (state_q)
      IDLE: begin
        if (mem_write) begin
          state_d = WR_PH;
          idx_d   = 2'd0;
          addr_d  = mem_addr;
          wdata_d = mem_data_write;
          load    = 1'b1;
        end else if (mem_read) begin
          addr_d = mem_addr;
          idx_d  = 2'd0;
          if (buf_hit) begin
            state_d = DONE;
            rdata_d = buf_rdata;
          end else begin
            state_d = RD_PH;
            load    = 1'b1;
          end
        end
      end
      RD_PH: begin
        if (phase_last) begin
          rd_asm_d = rd_cap;
          if (idx_q == 2'd2) begin
            state_d = DONE;
            idx_d   = 2'd0;
            rdata_d = rd_cap;
          end else begin
            idx_d = idx_q + 2'd1;
            load  = 1'b1;
          end
        end
      end
      WR_PH: begin
        if (phase_last) begin
          if (idx_q == 2'd2) begin
            state_d = DONE;
            idx_d   = 2'd0;
          end else begin
            idx_d = idx_q + 2'd1;
            load  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= 2'd0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rd_asm_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rd_asm_q <= rd_asm_d;
      rdata_q  <= rdata_d;
    end
  end

`ifdef MESM6_SRAM_RDBUF_EN
  logic        buf_valid_q, buf_valid_d;
  logic [14:0] buf_addr_q, buf_addr_d;
  logic [47:0] buf_data_q, buf_data_d;

  assign buf_hit   = buf_valid_q && (buf_addr_q == mem_addr);
  assign buf_rdata = buf_data_q;

  // a write to the buffered address refreshes the data so hits never go stale
  always_comb begin
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_data_d  = buf_data_q;
    if (rd_last) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = addr_q;
      buf_data_d  = rd_cap;
    end else if ((state_q == IDLE) && mem_write && buf_valid_q &&
                 (buf_addr_q == mem_addr)) begin
      buf_data_d = mem_data_write;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
    end
  end
`else
  assign buf_hit   = 1'b0;
  assign buf_rdata = '0;
`endif

  assign mem_done      = (state_q == DONE);
  assign mem_data_read = rdata_q;
  assign sram_addr     = {addr_q, idx_q};
  assign sram_dq_o     = get_half(wdata_q, idx_q);
  assign sram_ce       = (state_q == RD_PH) || (state_q == WR_PH);
  assign sram_oe       = (state_q == RD_PH);
  assign sram_we       = (state_q == WR_PH);

endmodule

// File: tb/tb_mesm6_sram_bridge.sv
// Self-checking bench for mesm6_sram_bridge: behavioural SRAM plus a word-level
// reference memory; directed cases followed by randomized reads/writes.
module tb_mesm6_sram_bridge;

  localparam int unsigned WS = 1;
  localparam int MISS_LAT  = 3 * (WS + 1) + 1;
  localparam int PH_CYCLES = 3 * (WS + 1);

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read;
  logic        mem_write;
  logic [14:0] mem_addr;
  logic [47:0] mem_data_write;
  logic        mem_done;
  logic [47:0] mem_data_read;
  logic [16:0] sram_addr;
  logic [15:0] sram_dq_o;
  logic [15:0] sram_dq_i;
  logic        sram_ce;
  logic        sram_oe;
  logic        sram_we;

  int vec_count = 0;
  int err_count = 0;

  logic [15:0] sram_mem [0:131071];
  logic [47:0] ref_mem  [0:32767];
  logic [47:0] last_read;
  bit          rb_valid;
  logic [14:0] rb_addr;

  int ce_cnt, oe_cnt, we_cnt, overlap_cnt, done_cnt;

  mesm6_sram_bridge #(.WAIT_STATES(WS)) dut (
    .clk            (clk),
    .reset          (reset),
    .mem_read       (mem_read),
    .mem_write      (mem_write),
    .mem_addr       (mem_addr),
    .mem_data_write (mem_data_write),
    .mem_done       (mem_done),
    .mem_data_read  (mem_data_read),
    .sram_addr      (sram_addr),
    .sram_dq_o      (sram_dq_o),
    .sram_dq_i      (sram_dq_i),
    .sram_ce        (sram_ce),
    .sram_oe        (sram_oe),
    .sram_we        (sram_we)
  );

  always #5 clk = ~clk;

  // asynchronous SRAM: reads combinational while enabled, writes on strobed edges
  assign sram_dq_i = (sram_ce && sram_oe) ? sram_mem[sram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (sram_ce && sram_we) sram_mem[sram_addr] <= sram_dq_o;
  end

  always @(negedge clk) begin
    if (sram_ce) ce_cnt++;
    if (sram_oe) oe_cnt++;
    if (sram_we) we_cnt++;
    if (sram_oe && sram_we) overlap_cnt++;
    if (mem_done) done_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [63:0] actual,
                             input logic [63:0] expected);
    vec_count++;
    if (actual !== expected) begin
      err_count++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic preload(input logic [14:0] a, input logic [47:0] w);
    sram_mem[{a, 2'd0}] = w[47:32];
    sram_mem[{a, 2'd1}] = w[31:16];
    sram_mem[{a, 2'd2}] = w[15:0];
    ref_mem[a]          = w;
  endtask

  // called at a negedge while the bridge is idle; returns at the negedge after mem_done
  task automatic applyStimulus(input bit wr, input logic [14:0] a,
                               input logic [47:0] d, input bit drop);
    int n;
    bit hit;
    int exp_lat;
`ifdef MESM6_SRAM_RDBUF_EN
    hit = !wr && rb_valid && (rb_addr == a);
`else
    hit = 1'b0;
`endif
    exp_lat     = hit ? 1 : MISS_LAT;
    ce_cnt      = 0;
    oe_cnt      = 0;
    we_cnt      = 0;
    overlap_cnt = 0;
    done_cnt    = 0;
    mem_write      = wr;
    mem_read       = !wr;
    mem_addr       = a;
    mem_data_write = d;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_done && n < 64);
    checkOutput(wr ? "wr_latency" : "rd_latency", 64'(n), 64'(exp_lat));
    if (wr) begin
      ref_mem[a] = d;
      checkOutput("rdata_hold", mem_data_read, last_read);
      checkOutput("we_cycles", 64'(we_cnt), 64'(PH_CYCLES));
      checkOutput("oe_during_wr", 64'(oe_cnt), 64'd0);
    end else begin
      checkOutput("rdata", mem_data_read, ref_mem[a]);
      last_read = ref_mem[a];
      rb_valid  = 1'b1;
      rb_addr   = a;
      checkOutput("oe_cycles", 64'(oe_cnt), hit ? 64'd0 : 64'(PH_CYCLES));
      checkOutput("we_during_rd", 64'(we_cnt), 64'd0);
    end
    checkOutput("ce_cycles", 64'(ce_cnt), hit ? 64'd0 : 64'(PH_CYCLES));
    checkOutput("oe_we_overlap", 64'(overlap_cnt), 64'd0);
    if (drop) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    @(negedge clk);
    checkOutput("done_pulse_end", 64'(mem_done), 64'd0);
    checkOutput("done_count", 64'(done_cnt), 64'd1);
  endtask

  initial begin
    logic [63:0] r64;
    logic [14:0] ra;
    bit          rw;

    reset          = 1'b1;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_addr       = '0;
    mem_data_write = '0;
    last_read      = '0;
    rb_valid       = 1'b0;
    rb_addr        = '0;
    for (int i = 0; i < 131072; i++) sram_mem[i] = 16'h0000;
    for (int i = 0; i < 32768; i++) ref_mem[i] = 48'h0;

    repeat (3) @(negedge clk);
    checkOutput("rst_mem_done", 64'(mem_done), 64'd0);
    checkOutput("rst_ce", 64'(sram_ce), 64'd0);
    checkOutput("rst_oe", 64'(sram_oe), 64'd0);
    checkOutput("rst_we", 64'(sram_we), 64'd0);
    checkOutput("rst_addr", 64'(sram_addr), 64'd0);
    checkOutput("rst_dq_o", 64'(sram_dq_o), 64'd0);
    checkOutput("rst_rdata", mem_data_read, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    preload(15'h1234, 48'hAAAA_BBBB_CCCC);
    applyStimulus(1'b0, 15'h1234, 48'h0, 1'b1);
    checkOutput("rd_1234", mem_data_read, 64'hAAAA_BBBB_CCCC);

    applyStimulus(1'b1, 15'h0001, 48'h1234_5678_9ABC, 1'b1);
    checkOutput("sram_h4", 64'(sram_mem[4]), 64'h1234);
    checkOutput("sram_h5", 64'(sram_mem[5]), 64'h5678);
    checkOutput("sram_h6", 64'(sram_mem[6]), 64'h9ABC);

    preload(15'h0010, 48'h1010_2020_3030);
    preload(15'h0011, 48'h4141_5252_6363);
    applyStimulus(1'b0, 15'h0010, 48'h0, 1'b0);
    applyStimulus(1'b0, 15'h0011, 48'h0, 1'b1);

    preload(15'h0020, 48'h0BAD_CAFE_F00D);
    applyStimulus(1'b0, 15'h0020, 48'h0, 1'b1);
    applyStimulus(1'b0, 15'h0020, 48'h0, 1'b1);
    applyStimulus(1'b1, 15'h0020, 48'h5555_6666_7777, 1'b1);
    applyStimulus(1'b0, 15'h0020, 48'h0, 1'b1);
    checkOutput("rd_after_wr", mem_data_read, 64'h5555_6666_7777);

    for (int k = 0; k < 40; k++) begin
      r64 = {$urandom, $urandom};
      ra  = 15'($urandom_range(0, 47));
      rw  = 1'($urandom_range(0, 1));
      applyStimulus(rw, ra, r64[47:0], ($urandom_range(0, 3) != 0));
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end

    // abort a write mid-phase; the scratch address is never read back
    applyStimulus(1'b0, 15'h0011, 48'h0, 1'b1);
    done_cnt       = 0;
    mem_write      = 1'b1;
    mem_addr       = 15'h7FFF;
    mem_data_write = 48'hFEED_FACE_BEEF;
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    mem_write = 1'b0;
    @(negedge clk);
    checkOutput("abort_ce", 64'(sram_ce), 64'd0);
    checkOutput("abort_oe", 64'(sram_oe), 64'd0);
    checkOutput("abort_we", 64'(sram_we), 64'd0);
    checkOutput("abort_rdata", mem_data_read, 64'd0);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("abort_no_done", 64'(done_cnt), 64'd0);
    rb_valid  = 1'b0;
    last_read = '0;
    applyStimulus(1'b0, 15'h0010, 48'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule

// File: doc/mesm6_sram_bridge.md
# mesm6_sram_bridge

Memory-side bridge directly downstream of the MESM-6 core's memory port. It accepts the core's 48-bit word read/write requests (15-bit word address, level request held until `mem_done`) and performs them as three sequential 16-bit accesses on an external asynchronous SRAM, with programmable wait states. It returns the assembled word and a one-cycle `mem_done` pulse.

## Interface
- `WAIT_STATES`, default 1: extra cycles per 16-bit phase; legal range 0..7.
- `clk`  in  1  clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `mem_read`  in  1  core read request; level, held until `mem_done`.
- `mem_write`  in  1  core write request; level, held until `mem_done`.
- `mem_addr`  in  15  word address; stable while the request is held.
- `mem_data_write`  in  48  write data; stable while the request is held.
- `mem_done`  out  1  one-cycle completion pulse.
- `mem_data_read`  out  48  read word; valid in the `mem_done` cycle and held until the next read completes.
- `sram_addr`  out  17  halfword address, `{mem_addr, idx[1:0]}`.
- `sram_dq_o`  out  16  SRAM write data.
- `sram_dq_i`  in  16  SRAM read data.
- `sram_ce`  out  1  chip enable, active-high.
- `sram_oe`  out  1  output enable, active-high.
- `sram_we`  out  1  write enable, active-high.

## Operation
- Halfword mapping:
  - idx 0 = bits 47:32
  - idx 1 = bits 31:16
  - idx 2 = bits 15:0
  - idx 3 is never generated.
- FSM states: IDLE, RD_PH, WR_PH, DONE.
- IDLE transitions:
  - `mem_write` = 1 → WR_PH, idx = 0.
  - else `mem_read` = 1 → RD_PH, idx = 0.
  - Address and write data are latched on entry.
  - Write has priority if both requests are asserted; the core never asserts both.
- Each phase lasts WAIT_STATES+1 cycles, counted by the wait counter.
- RD_PH:
  - `sram_ce` = `sram_oe` = 1 during the phase.
  - On the last cycle of the phase, `sram_dq_i` is captured into the idx slice of the read register.
  - idx advances; after idx 2 the FSM goes to DONE.
- WR_PH:
  - `sram_ce` = `sram_we` = 1 during the phase.
  - `sram_dq_o` = idx slice of the latched data.
  - After idx 2 the FSM goes to DONE.
- DONE:
  - `mem_done` = 1 for exactly one cycle.
  - For reads, `mem_data_read` is updated from the assembled register in this cycle.
  - Next state is always IDLE. A request still asserted in the following cycle is a new access, because the core advances its microcode on `mem_done`.
- `sram_addr` changes only on phase boundaries.
- `sram_we` is never asserted in the same cycle as `sram_oe`.
- The address is stable throughout each phase.

## Timing
- Reset values:
  - state = IDLE, idx = 0.
  - `mem_done`, `sram_ce`, `sram_oe`, `sram_we` = 0.
  - `sram_addr` = 0, `sram_dq_o` = 0, `mem_data_read` = 0.
- Latency from the request being sampled in IDLE to `mem_done`: 3·(WAIT_STATES+1)+1 cycles. With WAIT_STATES = 1 this is 7 cycles.
- Back-to-back accesses: minimum request-to-request spacing is latency+1, because of the IDLE cycle after DONE.
- Reset asserted mid-access:
  - The access is aborted.
  - All SRAM strobes are 0 from the next cycle.
  - No `mem_done` is issued.
  - `mem_data_read` is cleared to 0.
- If a request deasserts before `mem_done` (protocol violation), the bridge completes the access anyway and pulses `mem_done`.

## Configuration
- `MESM6_SRAM_RDBUF_EN` defined:
  - A one-entry read buffer holds the last read address, its data, and a valid bit.
  - A read whose address hits a valid buffer goes IDLE → DONE. Latency is 1 cycle and there is no SRAM activity.
  - Any write to the buffered address updates the buffer data.
  - Reset clears the valid bit.
- `MESM6_SRAM_RDBUF_EN` undefined: every read accesses the SRAM, with the latency given in Timing.

## Structure
- Shared package `mesm6_mem_pkg`:
  - state enum (IDLE, RD_PH, WR_PH, DONE)
  - `MESM6_WORD_W` = 48, `MESM6_HALF_W` = 16, `MESM6_ADDR_W` = 15
  - halfword count = 3
- Sub-module `mesm6_wait_counter`: 3-bit down-counter.
  - Loads WAIT_STATES on phase start.
  - Outputs `phase_last` when it reaches 0.

## Test plan
- Read `mem_addr` = 0x1234, SRAM model holds 0xAAAA / 0xBBBB / 0xCCCC at `{0x1234, 0..2}`, WAIT_STATES = 1 → `mem_done` after 7 cycles, `mem_data_read` = 0xAAAABBBBCCCC.
- Write 0x123456789ABC to 0x0001 → SRAM halfwords 0x1234 / 0x5678 / 0x9ABC at addresses 4, 5, 6; `sram_we` high 2 cycles each; `sram_oe` never high.
- Read held high across two consecutive accesses (0x10, then 0x11 after `mem_done`) → two separate `mem_done` pulses with correct data each; no merged access.
- Reset asserted in the 3rd cycle of a write → strobes 0 on the next cycle, no `mem_done`, FSM in IDLE.
- With `MESM6_SRAM_RDBUF_EN`: read 0x20 twice → second `mem_done` 1 cycle after the request with no SRAM strobes; write 0x20 then read → the new value is returned.
